// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: widths, opcodes,
// instruction field layout and FSM state encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned INSN_W = 16;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RIDX_W = 2;
  localparam int unsigned NREGS  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NOT = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  localparam int unsigned OP_LSB   = 13;
  localparam int unsigned RD_LSB   = 11;
  localparam int unsigned RA_LSB   = 9;
  localparam int unsigned RB_LSB   = 7;
  localparam int unsigned HALT_BIT = 6;
  localparam int unsigned RSVD_W   = 6;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] ra;
    logic [RIDX_W-1:0] rb;
    logic              halt;
    logic [RSVD_W-1:0] rsvd;
  } insn_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Split a raw ROM word into its fields using the documented bit positions.
  function automatic insn_t decode_insn(input logic [INSN_W-1:0] w);
    insn_t d;
    d.op   = w[OP_LSB +: OP_W];
    d.rd   = w[RD_LSB +: RIDX_W];
    d.ra   = w[RA_LSB +: RIDX_W];
    d.rb   = w[RB_LSB +: RIDX_W];
    d.halt = w[HALT_BIT];
    d.rsvd = w[RSVD_W-1:0];
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Program-ROM fetch bus and ALU operand/result bus between the controller
// (master) and the ROM/ALU datapath (slave).
interface alu_ctrl_if #(
  parameter int unsigned PROG_AW = 4
) ();

  logic [PROG_AW-1:0]            imem_addr;
  logic [alu_pkg::INSN_W-1:0]    imem_data;
  logic [alu_pkg::OP_W-1:0]      alu_s;
  logic [alu_pkg::DATA_W-1:0]    alu_a;
  logic [alu_pkg::DATA_W-1:0]    alu_b;
  logic [alu_pkg::DATA_W-1:0]    alu_m;

  modport master (
    output imem_addr,
    output alu_s,
    output alu_a,
    output alu_b,
    input  imem_data,
    input  alu_m
  );

  modport slave (
    input  imem_addr,
    input  alu_s,
    input  alu_a,
    input  alu_b,
    output imem_data,
    output alu_m
  );

endinterface

// File: rtl/alu_regbank.sv
// 4x8 register bank: two operand read ports, a host read port and one
// write port shared between the host (while idle) and write-back.
module alu_regbank
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_sel,
  input  logic              host_we,
  input  logic [RIDX_W-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              wb_we,
  input  logic [RIDX_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [RIDX_W-1:0] raddr_a,
  input  logic [RIDX_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [RIDX_W-1:0] host_raddr,
  output logic [DATA_W-1:0] host_rdata
);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         we_c;
  logic [RIDX_W-1:0]            waddr_c;
  logic [DATA_W-1:0]            wdata_c;

  // Host owns the write port only while the controller is idle.
  always_comb begin
    we_c    = 1'b0;
    waddr_c = '0;
    wdata_c = '0;
    if (host_sel) begin
      we_c    = host_we;
      waddr_c = host_waddr;
      wdata_c = host_wdata;
    end else begin
      we_c    = wb_we;
      waddr_c = wb_waddr;
      wdata_c = wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we_c) begin
      regs[waddr_c] <= wdata_c;
    end
  end

  assign rdata_a    = regs[raddr_a];
  assign rdata_b    = regs[raddr_b];
  assign host_rdata = regs[host_raddr];

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing controller: fetches ROM instructions, stages bank operands onto
// the external ALU, captures its result and writes it back to the bank.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned PROG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  alu_ctrl_if.master        bus,
  input  logic              host_we,
  input  logic [RIDX_W-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [RIDX_W-1:0] host_raddr,
  output logic [DATA_W-1:0] host_rdata,
  output logic              flag_z
);

  state_t             state;
  logic [PROG_AW-1:0] pc;
  insn_t              ir;
  insn_t              fetched;
  logic [DATA_W-1:0]  res;
  logic [RIDX_W-1:0]  raddr_a;
  logic [RIDX_W-1:0]  raddr_b;
  logic [DATA_W-1:0]  rdata_a;
  logic [DATA_W-1:0]  rdata_b;
  logic               unused_ir_bits;

  assign fetched        = decode_insn(bus.imem_data);
  assign unused_ir_bits = ^{ir.op, ir.rsvd};
  assign bus.imem_addr  = pc;

  // Operands are read while decoding so the registered ALU inputs are
  // already stable for the whole EXEC cycle; ir is not loaded until then.
  assign raddr_a = (state == DECODE) ? fetched.ra : ir.ra;
  assign raddr_b = (state == DECODE) ? fetched.rb : ir.rb;

  alu_regbank u_regbank (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_sel   (state == IDLE),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .wb_we      (state == WB),
    .wb_waddr   (ir.rd),
    .wb_wdata   (res),
    .raddr_a    (raddr_a),
    .raddr_b    (raddr_b),
    .rdata_a    (rdata_a),
    .rdata_b    (rdata_b),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata)
  );

  // FSM with registered outputs; ALU drive is zero outside EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      res       <= '0;
      flag_z    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bus.alu_s <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
    end else begin
      done      <= 1'b0;
      bus.alu_s <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          state <= DECODE;
        end
        DECODE: begin
          ir        <= fetched;
          bus.alu_s <= fetched.op;
          bus.alu_a <= rdata_a;
          bus.alu_b <= rdata_b;
          state     <= EXEC;
        end
        EXEC: begin
          res   <= bus.alu_m;
          state <= WB;
        end
        WB: begin
          flag_z <= (res == '0);
          pc     <= pc + PROG_AW'(1);
          if (ir.halt) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        DONE: begin
          pc    <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: directed vector table, hand-written multi-cycle
// sequences and random programs scored against an instruction-level model.
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int unsigned PAW   = 2;
  localparam int unsigned DEPTH = 1 << PAW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       host_we = 1'b0;
  logic [1:0] host_waddr = '0;
  logic [7:0] host_wdata = '0;
  logic [1:0] host_raddr = '0;
  logic [7:0] host_rdata;
  logic       flag_z;
  logic [15:0] rom [DEPTH];

  int vectors = 0;
  int miscompares = 0;

  alu_ctrl_if #(.PROG_AW(PAW)) bus ();

  alu_ctrl #(.PROG_AW(PAW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bus        (bus),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata),
    .flag_z     (flag_z)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: plain modulo-256 arithmetic.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      OP_ADD:  r = (int'(a) + int'(b)) % 256;
      OP_SUB:  r = (int'(a) - int'(b) + 256) % 256;
      OP_AND:  r = int'(a & b);
      OP_OR:   r = int'(a | b);
      OP_NOT:  r = 255 - int'(a);
      OP_XOR:  r = int'(a ^ b);
      OP_SHL:  r = (int'(a) * 2) % 256;
      default: r = int'(a) / 2;
    endcase
    return 8'(r);
  endfunction

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];
  assign bus.alu_m = alu_fn(bus.alu_s, bus.alu_a, bus.alu_b);

  function automatic logic [15:0] enc(input logic [2:0] op, input int rd, input int ra, input int rb, input bit halt);
    return {op, 2'(rd), 2'(ra), 2'(rb), halt, 6'b000000};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic host_write(input int idx, input logic [7:0] d);
    host_we = 1'b1; host_waddr = 2'(idx); host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic read_reg(input int idx, output logic [7:0] v);
    host_raddr = 2'(idx);
    #1;
    v = host_rdata;
  endtask

  task automatic load_regs(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
    host_write(0, r0); host_write(1, r1); host_write(2, r2); host_write(3, r3);
  endtask

  // Starts the loaded program and checks done latency plus single-cycle done.
  task automatic run_prog(input string name, input int exp_cycles);
    int j;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (!done && j < 200) begin
      @(negedge clk);
      j++;
    end
    check({name, " done latency"}, 32'(j), 32'(exp_cycles));
    @(negedge clk);
    check({name, " done/busy after"}, {30'd0, done, busy}, 32'd0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] regs [4];
    logic [15:0] prog [4];
    int         n;
    logic [7:0] er [4];
    logic       ez;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [7:0] v;
    logic [7:0] m [4];
    logic [15:0] w;
    int ndone, first, pc, n, h;
    logic z, halt;

    for (int i = 0; i < int'(DEPTH); i++) rom[i] = '0;

    tbl[0] = '{"add", '{8'h05, 8'h03, 8'h00, 8'h00},
               '{enc(OP_ADD, 2, 0, 1, 1), 16'h0, 16'h0, 16'h0}, 1,
               '{8'h05, 8'h03, 8'h08, 8'h00}, 1'b0};
    tbl[1] = '{"sub_xor", '{8'h05, 8'h03, 8'h00, 8'h00},
               '{enc(OP_SUB, 3, 1, 0, 0), enc(OP_XOR, 0, 0, 0, 1), 16'h0, 16'h0}, 2,
               '{8'h00, 8'h03, 8'h00, 8'hFE}, 1'b1};
    tbl[2] = '{"not", '{8'h0F, 8'h00, 8'h00, 8'h00},
               '{enc(OP_NOT, 1, 0, 0, 1), 16'h0, 16'h0, 16'h0}, 1,
               '{8'h0F, 8'hF0, 8'h00, 8'h00}, 1'b0};
    tbl[3] = '{"shr", '{8'h0F, 8'hF0, 8'h00, 8'h00},
               '{enc(OP_SHR, 2, 1, 0, 1), 16'h0, 16'h0, 16'h0}, 1,
               '{8'h0F, 8'hF0, 8'h78, 8'h00}, 1'b0};
    tbl[4] = '{"and_or", '{8'hC3, 8'h5A, 8'h00, 8'h00},
               '{enc(OP_AND, 2, 0, 1, 0), enc(OP_OR, 3, 0, 1, 1), 16'h0, 16'h0}, 2,
               '{8'hC3, 8'h5A, 8'h42, 8'hDB}, 1'b0};
    tbl[5] = '{"four_insn", '{8'hFF, 8'h01, 8'h00, 8'h00},
               '{enc(OP_ADD, 0, 0, 1, 0), enc(OP_SHL, 2, 1, 3, 0),
                 enc(OP_SUB, 3, 0, 1, 0), enc(OP_ADD, 1, 0, 0, 1)}, 4,
               '{8'h00, 8'h00, 8'h02, 8'hFF}, 1'b1};
    tbl[6] = '{"rsvd_bits", '{8'h10, 8'h20, 8'h30, 8'h40},
               '{enc(OP_XOR, 1, 2, 3, 1) | 16'h003F, 16'h0, 16'h0, 16'h0}, 1,
               '{8'h10, 8'h70, 8'h30, 8'h40}, 1'b0};

    // Power-on reset values
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst imem_addr", 32'(bus.imem_addr), 0);
    check("rst alu_s/a/b", {13'd0, bus.alu_s, bus.alu_a, bus.alu_b}, 0);
    check("rst flag_z", 32'(flag_z), 0);
    read_reg(0, v); check("rst host_rdata", 32'(v), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int t = 0; t < 7; t++) begin
      load_regs(tbl[t].regs[0], tbl[t].regs[1], tbl[t].regs[2], tbl[t].regs[3]);
      for (int i = 0; i < int'(DEPTH); i++) rom[i] = tbl[t].prog[i];
      run_prog(tbl[t].name, 4 * tbl[t].n);
      for (int r = 0; r < 4; r++) begin
        read_reg(r, v);
        check($sformatf("%s r%0d", tbl[t].name, r), 32'(v), 32'(tbl[t].er[r]));
      end
      check({tbl[t].name, " flag_z"}, 32'(flag_z), 32'(tbl[t].ez));
    end

    // ALU drive is only active in EXEC; write-back visible the next cycle
    load_regs(8'h05, 8'h03, 8'h00, 8'h00);
    rom[0] = enc(OP_ADD, 2, 0, 1, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("seqA fetch busy", 32'(busy), 1);
    check("seqA fetch alu_a", 32'(bus.alu_a), 0);
    @(negedge clk);
    check("seqA decode alu_a", 32'(bus.alu_a), 0);
    @(negedge clk);
    check("seqA exec alu_s", 32'(bus.alu_s), 32'(OP_ADD));
    check("seqA exec alu_a", 32'(bus.alu_a), 32'h05);
    check("seqA exec alu_b", 32'(bus.alu_b), 32'h03);
    @(negedge clk);
    check("seqA wb alu_a/b", {16'd0, bus.alu_a, bus.alu_b}, 0);
    @(negedge clk);
    check("seqA done", 32'(done), 1);
    read_reg(2, v); check("seqA r2", 32'(v), 32'h08);
    @(negedge clk);

    // start and host_we while busy are ignored
    load_regs(8'h05, 8'h03, 8'h00, 8'h00);
    rom[0] = enc(OP_SUB, 3, 1, 0, 0);
    rom[1] = enc(OP_XOR, 0, 0, 0, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    ndone = 0; first = -1;
    for (int j = 0; j < 20; j++) begin
      if (done) begin ndone++; if (first < 0) first = j; end
      if (j == 3 || j == 8) begin
        start = 1'b1; host_we = 1'b1; host_waddr = 2'd1; host_wdata = 8'hAA;
      end else begin
        start = 1'b0; host_we = 1'b0;
      end
      @(negedge clk);
    end
    check("seqB done count", 32'(ndone), 1);
    check("seqB done cycle", 32'(first), 8);
    check("seqB busy", 32'(busy), 0);
    read_reg(1, v); check("seqB r1 kept", 32'(v), 32'h03);
    read_reg(3, v); check("seqB r3", 32'(v), 32'hFE);
    check("seqB flag_z", 32'(flag_z), 1);

    // Reset during EXEC of the second instruction
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("seqC pre-rst alu_s", 32'(bus.alu_s), 32'(OP_XOR));
    check("seqC pre-rst imem_addr", 32'(bus.imem_addr), 1);
    rst_n = 1'b0;
    #1;
    check("seqC busy", 32'(busy), 0);
    check("seqC done", 32'(done), 0);
    check("seqC alu_s/a/b", {13'd0, bus.alu_s, bus.alu_a, bus.alu_b}, 0);
    check("seqC flag_z", 32'(flag_z), 0);
    check("seqC imem_addr", 32'(bus.imem_addr), 0);
    for (int r = 0; r < 4; r++) begin
      read_reg(r, v); check($sformatf("seqC r%0d", r), 32'(v), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_regs(8'h05, 8'h03, 8'h00, 8'h00);
    rom[0] = enc(OP_ADD, 2, 0, 1, 1);
    rom[1] = enc(OP_SUB, 2, 0, 1, 1);
    run_prog("seqC restart", 4);
    read_reg(2, v); check("seqC restart r2", 32'(v), 32'h08);

    // pc wraps without a halt; shl chain in r0
    load_regs(8'h01, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = enc(OP_SHL, 0, 0, 0, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int j = 0; j <= 20; j++) begin
      if (j % 4 == 0 && j < 24)
        check($sformatf("seqD imem_addr j%0d", j), 32'(bus.imem_addr), 32'((j / 4) % int'(DEPTH)));
      if (j == 20) begin
        read_reg(0, v); check("seqD r0 after 5 wb", 32'(v), 32'h20);
      end
      if (j < 20) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("seqD rst busy", 32'(busy), 0);
    read_reg(0, v); check("seqD rst r0", 32'(v), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random programs against the instruction-level model
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 4; r++) m[r] = 8'($urandom_range(0, 255));
      for (int i = 0; i < int'(DEPTH); i++) rom[i] = 16'($urandom_range(0, 65535));
      h = $urandom_range(0, int'(DEPTH) - 1);
      rom[h] = rom[h] | 16'h0040;
      load_regs(m[0], m[1], m[2], m[3]);
      pc = 0; n = 0; z = 1'b0; halt = 1'b0;
      while (!halt) begin
        w = rom[pc];
        m[w[12:11]] = alu_fn(w[15:13], m[w[10:9]], m[w[8:7]]);
        z = (m[w[12:11]] == 8'h00);
        halt = w[6];
        n++;
        pc = (pc + 1) % int'(DEPTH);
      end
      run_prog($sformatf("rand%0d", it), 4 * n);
      for (int r = 0; r < 4; r++) begin
        read_reg(r, v);
        check($sformatf("rand%0d r%0d", it, r), 32'(v), 32'(m[r]));
      end
      check($sformatf("rand%0d flag_z", it), 32'(flag_z), 32'(z));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
